// File: rtl/snd_synth.sv
// ============================================================================
//  Module   : snd_synth
//  Purpose  : CPU-written tone registers, NCH square-wave generators with
//             duration timers, and a mixer producing one unsigned PCM sample.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module snd_synth #(
   parameter int NCH      = 4,
   parameter int TICK_DIV = 50,
   parameter int DUR_DIV  = 1000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             snd_wen,
   input  logic [1:0]       w_param,
   input  logic [10:0]      w_index,
   input  logic [15:0]      w_val,
   output logic [7:0]       sample,
   output logic [NCH-1:0]   tone,
   output logic [NCH-1:0]   active
);

   localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_DW = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;
   localparam int c_SW = $clog2(15 * NCH + 1);
   localparam logic [c_PW-1:0]  c_PRESC_MAX  = c_PW'(TICK_DIV - 1);
   localparam logic [c_DW-1:0]  c_DPRESC_MAX = c_DW'(DUR_DIV - 1);
   localparam logic [c_SW+9:0]  c_SAMPLE_MAX = (c_SW + 10)'(255);

   logic [c_PW-1:0]   r_presc;
   logic [c_DW-1:0]   r_dpresc;
   logic              w_tick;
   logic              w_unit;
   logic [4*NCH-1:0]  w_vol_all;
   logic [c_SW-1:0]   w_sum;
   logic [c_SW+9:0]   w_wide;

   assign w_tick = (r_presc == c_PRESC_MAX);
   assign w_unit = w_tick && (r_dpresc == c_DPRESC_MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_presc  <= '0;
         r_dpresc <= '0;
      end else begin
         if (w_tick) r_presc <= '0;
         else        r_presc <= r_presc + 1'b1;
         if (w_tick) begin
            if (w_unit) r_dpresc <= '0;
            else        r_dpresc <= r_dpresc + 1'b1;
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [15:0] r_period;
      logic [15:0] r_dur;
      logic [15:0] r_phase;
      logic [3:0]  r_vol;
      logic        r_en;
      logic        r_tone;
      logic        w_hit;

      assign w_hit = snd_wen && (w_index == 11'(c));

      // Tick/unit updates first; a CPU write later in the block overrides them.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_period <= '0;
            r_dur    <= '0;
            r_phase  <= '0;
            r_vol    <= '0;
            r_en     <= 1'b0;
            r_tone   <= 1'b0;
         end else begin
            if (!r_en || (r_period == 16'd0)) begin
               r_tone  <= 1'b0;
               r_phase <= '0;
            end else if (w_tick) begin
               if (r_phase == 16'd0) begin
                  r_tone  <= ~r_tone;
                  r_phase <= r_period - 16'd1;
               end else begin
                  r_phase <= r_phase - 16'd1;
               end
            end

            if (w_unit && r_en && (r_dur != 16'd0) && !(w_hit && (w_param == 2'd2))) begin
               r_dur <= r_dur - 16'd1;
               if (r_dur == 16'd1) r_en <= 1'b0;
            end

            if (w_hit) begin
               case (w_param)
                  2'd0:    r_period <= w_val;
                  2'd1:    r_vol    <= w_val[3:0];
                  2'd2:    r_dur    <= w_val;
                  default: begin
                     r_en <= w_val[0];
                     if (w_val[1]) begin
                        r_phase <= '0;
                        r_tone  <= 1'b0;
                     end
                  end
               endcase
            end
         end
      end

      assign tone[c]            = r_tone;
      assign active[c]          = r_en;
      assign w_vol_all[4*c +: 4] = r_vol;
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         if (tone[i]) w_sum = w_sum + c_SW'(w_vol_all[4*i +: 4]);
      end
   end

   assign w_wide = {8'd0, w_sum, 2'b00};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                    sample <= '0;
      else if (w_wide > c_SAMPLE_MAX) sample <= 8'hFF;
      else                            sample <= w_wide[7:0];
   end

endmodule

`default_nettype wire

// File: tb/tb_snd_synth.sv
// ============================================================================
//  Module   : tb_snd_synth
//  Purpose  : Self-checking bench for snd_synth (TICK_DIV=2, DUR_DIV=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snd_synth;
   localparam int NCH = 4;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             snd_wen = 1'b0;
   logic [1:0]       w_param = '0;
   logic [10:0]      w_index = '0;
   logic [15:0]      w_val = '0;
   logic [7:0]       sample;
   logic [NCH-1:0]   tone;
   logic [NCH-1:0]   active;

   int               n_cmp = 0;
   int               n_fail = 0;
   int               cyc;
   logic [31:0]      q_exp[$];

   snd_synth #(.NCH(NCH), .TICK_DIV(2), .DUR_DIV(4)) dut (
      .clk(clk), .resetn(resetn), .snd_wen(snd_wen), .w_param(w_param),
      .w_index(w_index), .w_val(w_val), .sample(sample), .tone(tone), .active(active)
   );

   always #5 clk = ~clk;

   // Posedges since reset release: ticks land on even counts, unit pulses on multiples of 8.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] v);
      snd_wen = 1'b1; w_param = p; w_index = idx; w_val = v;
      @(negedge clk);
      snd_wen = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      snd_wen = 1'b0;
      resetn  = 1'b0;
      repeat (2) @(negedge clk);
      resetn  = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      do_reset();
      q_exp.push_back(32'd0); q_exp.push_back(32'd0); q_exp.push_back(32'd0);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL reset_sample: got %0d expected %0d", sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, tone} !== e) begin n_fail++; $display("FAIL reset_tone: got %b expected %0d", tone, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, active} !== e) begin n_fail++; $display("FAIL reset_active: got %b expected %0d", active, e); end

      wr(2'd0, 11'd0, 16'd3); wr(2'd1, 11'd0, 16'd15); wr(2'd3, 11'd0, 16'd1);
      repeat (4) @(negedge clk);
      q_exp.push_back(32'd60);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL premix_sample: got %0d expected %0d", sample, e); end

      #2 resetn = 1'b0;
      #1;
      q_exp.push_back(32'd0); q_exp.push_back(32'd0); q_exp.push_back(32'd0);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL async_sample: got %0d expected %0d", sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, tone} !== e) begin n_fail++; $display("FAIL async_tone: got %b expected %0d", tone, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, active} !== e) begin n_fail++; $display("FAIL async_active: got %b expected %0d", active, e); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_tone();
      logic [31:0] e;
      logic        prev;
      int          last;
      int          k;
      do_reset();
      wr(2'd0, 11'd0, 16'd3); wr(2'd1, 11'd0, 16'd15); wr(2'd3, 11'd0, 16'd1);
      q_exp.push_back(32'b0001);
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, active} !== e) begin n_fail++; $display("FAIL tone_active: got %b expected %0d", active, e); end
      prev = tone[0];
      last = -1;
      for (int n = 0; n < 5; n++) begin
         k = 0;
         while (tone[0] == prev && k < 20) begin @(negedge clk); k++; end
         if (k >= 20) begin
            n_cmp++; n_fail++;
            $display("FAIL tone_edge_timeout: got no edge in %0d cycles expected edge within 6", k);
            break;
         end
         q_exp.push_back(prev ? 32'd60 : 32'd0);
         e = q_exp.pop_front(); n_cmp++;
         if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL tone_sample_latency: got %0d expected %0d", sample, e); end
         if (last >= 0) begin
            q_exp.push_back(32'd6);
            e = q_exp.pop_front(); n_cmp++;
            if (32'(cyc - last) !== e) begin n_fail++; $display("FAIL tone_half_period: got %0d expected %0d", cyc - last, e); end
         end
         last = cyc;
         prev = tone[0];
         q_exp.push_back(prev ? 32'd60 : 32'd0);
         @(negedge clk);
         e = q_exp.pop_front(); n_cmp++;
         if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL tone_sample: got %0d expected %0d", sample, e); end
      end
   endtask

   task automatic test_duration();
      logic [31:0] e;
      int          c_en;
      int          k;
      logic        hi;
      do_reset();
      wr(2'd2, 11'd1, 16'd2); wr(2'd0, 11'd1, 16'd1); wr(2'd1, 11'd1, 16'd15); wr(2'd3, 11'd1, 16'd1);
      c_en = cyc;
      q_exp.push_back(32'd1);
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, active[1]} !== e) begin n_fail++; $display("FAIL dur_active_start: got %0d expected %0d", active[1], e); end
      q_exp.push_back(32'((c_en / 8 + 2) * 8));
      k = 0;
      while (active[1] && k < 40) begin @(negedge clk); k++; end
      e = q_exp.pop_front(); n_cmp++;
      if (k >= 40) begin n_fail++; $display("FAIL dur_expiry_timeout: got active after %0d cycles expected clear at %0d", k, e); end
      else if (32'(cyc) !== e) begin n_fail++; $display("FAIL dur_expiry_cycle: got %0d expected %0d", cyc, e); end
      repeat (2) @(negedge clk);
      hi = 1'b0;
      repeat (10) begin @(negedge clk); if (tone[1]) hi = 1'b1; end
      q_exp.push_back(32'd0); q_exp.push_back(32'd0);
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, hi} !== e) begin n_fail++; $display("FAIL dur_tone_after: got %0d expected %0d", hi, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL dur_sample_after: got %0d expected %0d", sample, e); end
   endtask

   task automatic test_bad_index();
      logic [31:0] e;
      do_reset();
      wr(2'd0, 11'd0, 16'd1000); wr(2'd1, 11'd0, 16'd15); wr(2'd3, 11'd0, 16'd1);
      repeat (3) @(negedge clk);
      q_exp.push_back(32'd60);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL badidx_pre_sample: got %0d expected %0d", sample, e); end
      wr(2'd1, 11'd4, 16'd9); wr(2'd1, 11'h404, 16'd9); wr(2'd3, 11'd4, 16'd3);
      wr(2'd3, 11'h7FF, 16'd1); wr(2'd0, 11'd5, 16'd1);
      repeat (2) @(negedge clk);
      q_exp.push_back(32'd60); q_exp.push_back(32'b0001); q_exp.push_back(32'b0001);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL badidx_sample: got %0d expected %0d", sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, active} !== e) begin n_fail++; $display("FAIL badidx_active: got %b expected %0d", active, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, tone} !== e) begin n_fail++; $display("FAIL badidx_tone: got %b expected %0d", tone, e); end
   endtask

   task automatic test_mix();
      logic [31:0] e;
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         wr(2'd0, 11'(c), 16'd1000); wr(2'd1, 11'(c), 16'd15); wr(2'd3, 11'(c), 16'd1);
      end
      repeat (3) @(negedge clk);
      q_exp.push_back(32'd240); q_exp.push_back(32'hF);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL mix_all_sample: got %0d expected %0d", sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, tone} !== e) begin n_fail++; $display("FAIL mix_all_tone: got %b expected %0d", tone, e); end
      wr(2'd0, 11'd2, 16'd0);
      q_exp.push_back(32'b1011); q_exp.push_back(32'd240); q_exp.push_back(32'd180);
      @(negedge clk);
      e = q_exp.pop_front(); n_cmp++;
      if ({28'd0, tone} !== e) begin n_fail++; $display("FAIL mix_p0_tone: got %b expected %0d", tone, e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL mix_p0_latency: got %0d expected %0d", sample, e); end
      @(negedge clk);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL mix_p0_sample: got %0d expected %0d", sample, e); end
      wr(2'd1, 11'd3, 16'd5);
      q_exp.push_back(32'd140);
      @(negedge clk);
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL mix_vol_sample: got %0d expected %0d", sample, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      int          base;
      int          k;
      int          w_edge;
      int          exp_rise;
      do_reset();
      wr(2'd0, 11'd0, 16'd1000); wr(2'd1, 11'd0, 16'd15); wr(2'd2, 11'd0, 16'd1); wr(2'd3, 11'd0, 16'd1);
      k = 0;
      while ((cyc % 8) != 7 && k < 16) begin @(negedge clk); k++; end
      base = cyc + 1;
      wr(2'd2, 11'd0, 16'd5);
      q_exp.push_back(32'd1);
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, active[0]} !== e) begin n_fail++; $display("FAIL race_dur_wins: got %0d expected %0d", active[0], e); end
      while (cyc < base + 39) @(negedge clk);
      q_exp.push_back(32'd1); q_exp.push_back(32'd0);
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, active[0]} !== e) begin n_fail++; $display("FAIL race_dur5_before: got %0d expected %0d", active[0], e); end
      @(negedge clk);
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, active[0]} !== e) begin n_fail++; $display("FAIL race_dur5_expiry: got %0d expected %0d", active[0], e); end

      wr(2'd0, 11'd1, 16'd3); wr(2'd1, 11'd1, 16'd15); wr(2'd3, 11'd1, 16'd1);
      k = 0;
      while (!tone[1] && k < 20) begin @(negedge clk); k++; end
      repeat (2) @(negedge clk);
      w_edge   = cyc + 1;
      exp_rise = ((w_edge % 2) == 0) ? w_edge + 2 : w_edge + 1;
      wr(2'd3, 11'd1, 16'd3);
      q_exp.push_back(32'd0); q_exp.push_back(32'd60);
      q_exp.push_back(32'(exp_rise)); q_exp.push_back(32'(exp_rise + 6));
      e = q_exp.pop_front(); n_cmp++;
      if ({31'd0, tone[1]} !== e) begin n_fail++; $display("FAIL restart_tone_clear: got %0d expected %0d", tone[1], e); end
      e = q_exp.pop_front(); n_cmp++;
      if ({24'd0, sample} !== e) begin n_fail++; $display("FAIL restart_sample_hold: got %0d expected %0d", sample, e); end
      k = 0;
      while (!tone[1] && k < 10) begin @(negedge clk); k++; end
      e = q_exp.pop_front(); n_cmp++;
      if (32'(cyc) !== e) begin n_fail++; $display("FAIL restart_rise_cycle: got %0d expected %0d", cyc, e); end
      k = 0;
      while (tone[1] && k < 10) begin @(negedge clk); k++; end
      e = q_exp.pop_front(); n_cmp++;
      if (32'(cyc) !== e) begin n_fail++; $display("FAIL restart_fall_cycle: got %0d expected %0d", cyc, e); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1ms expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_tone();
      test_duration();
      test_bad_index();
      test_mix();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
